// File: rtl/dmem_mmio_pkg.sv
// Shared constants for the data-memory / MMIO stage: window offsets,
// STATUS bit positions and the address-decode region type.
package dmem_mmio_pkg;

  localparam logic [31:0] OFF_OUT_DATA = 32'h0000_0000;
  localparam logic [31:0] OFF_STATUS   = 32'h0000_0004;
  localparam logic [31:0] OFF_CYCLES   = 32'h0000_0008;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_RAM,
    REG_OUT,
    REG_STATUS,
    REG_CYCLES
  } region_e;

endpackage

// File: rtl/dmem_mmio_if.sv
// Bus bundle between the CPU core / host / result consumer and dmem_mmio.
interface dmem_mmio_if #(
  parameter int RAM_WORDS = 256
);
  localparam int AW = $clog2(RAM_WORDS);

  logic          MemWrite;
  logic [31:0]   ALUResult;
  logic [31:0]   WriteData;
  logic [31:0]   ReadData;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [31:0]   load_data;
  logic          out_valid;
  logic [31:0]   out_data;
  logic          out_ready;

  modport slave (
    input  MemWrite, ALUResult, WriteData, load_en, load_addr, load_data, out_ready,
    output ReadData, out_valid, out_data
  );

  modport master (
    output MemWrite, ALUResult, WriteData, load_en, load_addr, load_data, out_ready,
    input  ReadData, out_valid, out_data
  );
endinterface

// File: rtl/dmem_mmio_sync_fifo.sv
// Synchronous FIFO with combinational head (no fall-through on push into an
// empty FIFO). A push while full is accepted only if a pop happens that cycle.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push_i,
  input  logic [WIDTH-1:0]   push_data_i,
  input  logic               pop_i,
  output logic               full_o,
  output logic               empty_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [WIDTH-1:0]   head_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int unsigned DEPTH_U = DEPTH;
  localparam logic [PW:0] FULL_CNT = DEPTH_U[PW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign count_o = count_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end
endmodule

// File: rtl/dmem_mmio.sv
// Data-memory stage: word RAM with host preload, plus an MMIO window holding
// a result FIFO, a status register and a free-running cycle counter.
module dmem_mmio
  import dmem_mmio_pkg::*;
#(
  parameter int          RAM_WORDS  = 256,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'h0000_0400
) (
  input  logic       clk,
  input  logic       reset,
  dmem_mmio_if.slave bus
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam logic [29:0] RAM_WORDS_W = 30'(RAM_WORDS);

  logic [31:0] ram_q [RAM_WORDS];
  logic [31:0] cycles_q, cycles_d;
  logic        ovf_q, ovf_d;
  logic [31:0] addr_word;
  logic [1:0]  unused_lsb;
  logic [AW-1:0] ram_idx;
  region_e     region;
  logic [31:0] rdata;

  logic        fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_drop;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic [31:0] fifo_head;

  // Byte offsets are ignored: every access is a whole word.
  assign addr_word  = {bus.ALUResult[31:2], 2'b00};
  assign unused_lsb = bus.ALUResult[1:0];
  assign ram_idx    = bus.ALUResult[AW+1:2];

  // Address decode into one region; anything unrecognised reads 0 and drops writes.
  always_comb begin
    region = REG_NONE;
    if (bus.ALUResult[31:2] < RAM_WORDS_W)       region = REG_RAM;
    else if (addr_word == MMIO_BASE + OFF_OUT_DATA) region = REG_OUT;
    else if (addr_word == MMIO_BASE + OFF_STATUS)   region = REG_STATUS;
    else if (addr_word == MMIO_BASE + OFF_CYCLES)   region = REG_CYCLES;
  end

  // Host preload wins over a same-cycle CPU store.
  always_ff @(posedge clk) begin
    if (bus.load_en)
      ram_q[bus.load_addr] <= bus.load_data;
    else if (bus.MemWrite && region == REG_RAM)
      ram_q[ram_idx] <= bus.WriteData;
  end

  assign fifo_push = bus.MemWrite && region == REG_OUT;
  assign fifo_pop  = bus.out_ready && !fifo_empty;
  assign fifo_drop = fifo_push && fifo_full && !fifo_pop;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (fifo_push),
    .push_data_i (bus.WriteData),
    .pop_i       (fifo_pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count),
    .head_o      (fifo_head)
  );

  // Sticky overflow (drop beats clear) and cycle counter (CPU write beats increment).
  always_comb begin
    ovf_d    = ovf_q;
    cycles_d = cycles_q + 32'd1;
    if (bus.MemWrite && region == REG_STATUS && bus.WriteData[ST_OVF]) ovf_d = 1'b0;
    if (fifo_drop) ovf_d = 1'b1;
    if (bus.MemWrite && region == REG_CYCLES) cycles_d = bus.WriteData;
  end

  // Status/counter state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q    <= 1'b0;
      cycles_q <= '0;
    end else begin
      ovf_q    <= ovf_d;
      cycles_q <= cycles_d;
    end
  end

  // Combinational load data; returns pre-write state in a store cycle.
  always_comb begin
    rdata = '0;
    case (region)
      REG_RAM:    rdata = ram_q[ram_idx];
      REG_STATUS: begin
        rdata[ST_EMPTY] = fifo_empty;
        rdata[ST_FULL]  = fifo_full;
        rdata[ST_OVF]   = ovf_q;
      end
      REG_CYCLES: rdata = cycles_q;
      default:    rdata = '0;
    endcase
  end

  assign bus.ReadData  = rdata;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = fifo_head;
endmodule

// File: tb/tb_dmem_mmio.sv
// Directed bench for dmem_mmio with a queue scoreboard for the result FIFO.
// RAM_WORDS is 128 so that byte address 0x300 lies in the unmapped gap
// between RAM (0x000-0x1FF) and the MMIO window at 0x400.
module tb_dmem_mmio;
  localparam int RAM_WORDS = 128;
  localparam int DEPTH     = 8;
  localparam logic [31:0] BASE = 32'h0000_0400;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_mmio_if #(.RAM_WORDS(RAM_WORDS)) bus ();

  dmem_mmio #(
    .RAM_WORDS  (RAM_WORDS),
    .FIFO_DEPTH (DEPTH),
    .MMIO_BASE  (BASE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_asserts = 0;
  int n_fail    = 0;
  logic [31:0] sb[$];
  int  model_cnt = 0;
  logic model_ovf = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-14s observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [31:0] addr, input logic [31:0] data);
    bus.MemWrite  = 1'b1;
    bus.ALUResult = addr;
    bus.WriteData = data;
    step();
    bus.MemWrite  = 1'b0;
  endtask

  task automatic cpu_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    bus.ALUResult = addr;
    #1;
    check(tag, bus.ReadData, exp);
  endtask

  // Model of a push with no concurrent pop.
  task automatic push_word(input logic [31:0] data);
    if (model_cnt < DEPTH) begin
      sb.push_back(data);
      model_cnt++;
    end else begin
      model_ovf = 1'b1;
    end
    cpu_write(BASE, data);
  endtask

  function automatic logic [31:0] model_status();
    return {29'b0, model_ovf, model_cnt == DEPTH, model_cnt == 0};
  endfunction

  task automatic drain_all();
    int budget = 50;
    logic [31:0] exp;
    bus.out_ready = 1'b1;
    while (sb.size() > 0 && budget > 0) begin
      if (bus.out_valid) begin
        exp = sb.pop_front();
        model_cnt--;
        check("fifo_head", bus.out_data, exp);
      end
      step();
      budget--;
    end
    if (sb.size() != 0) begin
      n_asserts++;
      n_fail++;
      $display("FAIL drain_timeout: observed %0d words left, expected 0", sb.size());
      sb.delete();
      model_cnt = 0;
    end
    bus.out_ready = 1'b0;
    check("drained_valid", {31'b0, bus.out_valid}, 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    bus.MemWrite = 1'b0; bus.ALUResult = '0; bus.WriteData = '0;
    bus.load_en = 1'b0; bus.load_addr = '0; bus.load_data = '0;
    bus.out_ready = 1'b0;

    // 1: reset state and counter start
    step(); step();
    reset = 1'b0;
    cpu_read("rst_status", BASE + 32'h4, 32'h1);
    check("rst_valid", {31'b0, bus.out_valid}, 32'h0);
    check("rst_data", bus.out_data, 32'h0);
    repeat (5) step();
    cpu_read("cycles5", BASE + 32'h8, 32'd5);

    // 2: host preload, CPU store/load, unmapped
    bus.load_en = 1'b1; bus.load_addr = 7'd3; bus.load_data = 32'hDEAD_BEEF;
    step();
    bus.load_en = 1'b0;
    cpu_read("ram3_host", 32'h0000_000C, 32'hDEAD_BEEF);
    cpu_write(32'h0000_0010, 32'h0000_1234);
    cpu_read("ram4_cpu", 32'h0000_0010, 32'h0000_1234);
    cpu_read("ram4_bytelsb", 32'h0000_0013, 32'h0000_1234);
    cpu_write(32'h0000_0300, 32'h5555_AAAA);
    cpu_read("unmapped", 32'h0000_0300, 32'h0);
    cpu_read("above_win", BASE + 32'hC, 32'h0);
    cpu_read("out_data_rd", BASE, 32'h0);
    // read during store returns old value
    bus.MemWrite = 1'b1; bus.ALUResult = 32'h10; bus.WriteData = 32'h0000_5678;
    #1;
    check("rd_during_wr", bus.ReadData, 32'h0000_1234);
    step();
    bus.MemWrite = 1'b0;
    cpu_read("ram4_new", 32'h0000_0010, 32'h0000_5678);

    // 3: host load beats CPU store
    bus.load_en = 1'b1; bus.load_addr = 7'd5; bus.load_data = 32'h0000_5555;
    cpu_write(32'h0000_0014, 32'h0000_9999);
    bus.load_en = 1'b0;
    cpu_read("host_wins", 32'h0000_0014, 32'h0000_5555);

    // 4: overflow on 9th push, drain, clear overflow
    for (int i = 1; i <= 9; i++) push_word(i);
    cpu_read("status_ovf", BASE + 32'h4, model_status());
    check("status_ovf6", model_status(), 32'h6);
    drain_all();
    cpu_write(BASE + 32'h4, 32'h4);
    model_ovf = 1'b0;
    cpu_read("status_clr", BASE + 32'h4, model_status());

    // 5: full with simultaneous push/pop
    for (int i = 0; i < 8; i++) push_word(32'h10 + i);
    bus.MemWrite = 1'b1; bus.ALUResult = BASE; bus.WriteData = 32'hAA;
    bus.out_ready = 1'b1;
    #1;
    check("fullpp_head", bus.out_data, sb.pop_front());
    sb.push_back(32'hAA);
    step();
    bus.MemWrite = 1'b0; bus.out_ready = 1'b0;
    cpu_read("fullpp_stat", BASE + 32'h4, model_status());
    drain_all();
    // mid-stream reset
    for (int i = 0; i < 3; i++) push_word(32'h31 + i);
    check("pre_rst_valid", {31'b0, bus.out_valid}, 32'h1);
    reset = 1'b1;
    step();
    sb.delete(); model_cnt = 0; model_ovf = 1'b0;
    check("mid_rst_valid", {31'b0, bus.out_valid}, 32'h0);
    check("mid_rst_data", bus.out_data, 32'h0);
    reset = 1'b0;
    cpu_read("ram_kept", 32'h0000_000C, 32'hDEAD_BEEF);
    cpu_read("post_rst_st", BASE + 32'h4, model_status());

    // 6: counter write and wrap
    cpu_write(BASE + 32'h8, 32'hFFFF_FFFE);
    cpu_read("cyc_written", BASE + 32'h8, 32'hFFFF_FFFE);
    step();
    cpu_read("cyc_max", BASE + 32'h8, 32'hFFFF_FFFF);
    step();
    cpu_read("cyc_wrap", BASE + 32'h8, 32'h0);
    step();
    cpu_read("cyc_after", BASE + 32'h8, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
